// File: rtl/ws2812_rx_pkg.sv
// Shared definitions for the WS2812 receive path and the LED output stage.
package leaflab_pkg;

  localparam int unsigned PIXEL_BITS = 24;

  // Default timing for a 12 MHz system clock.
  localparam int unsigned DEF_BIT_THRESH_CYC = 8;    // ~0.67 us
  localparam int unsigned DEF_MIN_HIGH_CYC   = 2;
  localparam int unsigned DEF_RESET_CYC      = 600;  // 50 us

  localparam int unsigned HIGH_CNT_W = 8;

  typedef enum logic [0:0] {
    CAPTURE,
    FORWARD
  } rx_state_t;

  typedef logic [PIXEL_BITS-1:0] pixel_t;

endpackage

// File: rtl/ws2812_rx_if.sv
// Serial in/out and captured-pixel signals of the WS2812 receiver.
interface ws2812_rx_if;
  import leaflab_pkg::*;

  logic   i_serial;
  logic   o_serial;
  pixel_t o_pixel;
  logic   o_pixel_valid;
  logic   o_latch;
  logic   o_frame_err;

  // Drives the serial line and consumes the decoder outputs.
  modport master (
    output i_serial,
    input  o_serial,
    input  o_pixel,
    input  o_pixel_valid,
    input  o_latch,
    input  o_frame_err
  );

  // The decoder itself.
  modport slave (
    input  i_serial,
    output o_serial,
    output o_pixel,
    output o_pixel_valid,
    output o_latch,
    output o_frame_err
  );

endinterface

// File: rtl/ws2812_rx_serial_sync.sv
// 2-FF synchronizer with a history stage; produces level plus rise/fall strobes.
module serial_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_serial,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic s1_q, s2_q, s3_q;

  // Synchronize the asynchronous line and keep one cycle of history.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= i_serial;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign o_level = s2_q;
  assign o_rise  = ~s3_q & s2_q;
  assign o_fall  = s3_q & ~s2_q;

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 receiver: decodes the first 24-bit GRB pixel of a frame and forwards the rest.
module ws2812_rx
  import leaflab_pkg::*;
#(
  parameter int unsigned BIT_THRESH_CYC = DEF_BIT_THRESH_CYC,
  parameter int unsigned MIN_HIGH_CYC   = DEF_MIN_HIGH_CYC,
  parameter int unsigned RESET_CYC      = DEF_RESET_CYC
) (
  input logic        i_clk,
  input logic        i_rst,
  ws2812_rx_if.slave bus
);

  localparam int unsigned LowW = $clog2(RESET_CYC + 1);
  localparam logic [LowW-1:0]       LowMax  = LowW'(RESET_CYC);
  localparam logic [HIGH_CNT_W-1:0] HighMax = '1;
  localparam logic [HIGH_CNT_W-1:0] ThreshH = HIGH_CNT_W'(BIT_THRESH_CYC);
  localparam logic [HIGH_CNT_W-1:0] MinH    = HIGH_CNT_W'(MIN_HIGH_CYC);
  localparam logic [4:0]            LastBit = 5'(PIXEL_BITS - 1);

  logic s2, rise, fall;

  serial_sync u_sync (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_serial (bus.i_serial),
    .o_level  (s2),
    .o_rise   (rise),
    .o_fall   (fall)
  );

  logic [HIGH_CNT_W-1:0] high_q, high_d;
  logic [LowW-1:0]       low_q, low_d;
  logic                  end_seen_q, end_seen_d;
  logic                  frame_end, valid_fall, bit_val;

  // Next-state of the pulse-width and idle counters, both saturating.
  always_comb begin
    high_d = high_q;
    if (rise) begin
      high_d = HIGH_CNT_W'(1);
    end else if (s2 && (high_q != HighMax)) begin
      high_d = high_q + 1'b1;
    end

    low_d = low_q;
    if (s2) begin
      low_d = '0;
    end else if (low_q != LowMax) begin
      low_d = low_q + 1'b1;
    end

    end_seen_d = (low_q == LowMax);
  end

  // Counter state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      high_q     <= '0;
      low_q      <= '0;
      end_seen_q <= 1'b0;
    end else begin
      high_q     <= high_d;
      low_q      <= low_d;
      end_seen_q <= end_seen_d;
    end
  end

  // Frame end fires once, in the first cycle the idle counter sits at saturation.
  assign frame_end  = (low_q == LowMax) && !end_seen_q;
  assign valid_fall = fall && (high_q >= MinH);
  assign bit_val    = (high_q >= ThreshH);

  rx_state_t      state_q;
  pixel_t         shift_q;
  logic [4:0]     bit_cnt_q;
  pixel_t         pixel_q;
  logic           valid_q, latch_q, err_q, serial_q;

  // Capture/forward FSM with registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= CAPTURE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      pixel_q   <= '0;
      valid_q   <= 1'b0;
      latch_q   <= 1'b0;
      err_q     <= 1'b0;
      serial_q  <= 1'b0;
    end else begin
      valid_q  <= 1'b0;
      latch_q  <= 1'b0;
      err_q    <= 1'b0;
      serial_q <= 1'b0;
      unique case (state_q)
        CAPTURE: begin
          if (valid_fall) begin
            if (bit_cnt_q == LastBit) begin
              pixel_q   <= {shift_q[PIXEL_BITS-2:0], bit_val};
              valid_q   <= 1'b1;
              shift_q   <= '0;
              bit_cnt_q <= '0;
              state_q   <= FORWARD;
            end else begin
              shift_q   <= {shift_q[PIXEL_BITS-2:0], bit_val};
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else if (frame_end) begin
            // A partial pixel is dropped; an empty frame is silent.
            err_q     <= (bit_cnt_q != '0);
            shift_q   <= '0;
            bit_cnt_q <= '0;
          end
        end
        FORWARD: begin
          serial_q <= s2;
          if (frame_end) begin
            latch_q <= 1'b1;
            state_q <= CAPTURE;
          end
        end
        default: state_q <= CAPTURE;
      endcase
    end
  end

  assign bus.o_serial      = serial_q;
  assign bus.o_pixel       = pixel_q;
  assign bus.o_pixel_valid = valid_q;
  assign bus.o_latch       = latch_q;
  assign bus.o_frame_err   = err_q;

endmodule
